// File: rtl/byte_serial_adder_seq.sv
// byte_serial_adder_seq
// Performs a WIDTH-bit add or subtract one byte per clock on an external
// 8-bit ripple-carry adder. The carry is registered between byte slices and
// the result is assembled byte by byte, so no wide combinational carry chain
// is needed. Subtraction is A + ~B + 1.
module byte_serial_adder_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [7:0]       add_a,
    output logic [7:0]       add_b,
    output logic             add_cy_in,
    input  logic [7:0]       add_sum,
    input  logic             add_cy_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cy_out,
    output logic             ovf,
    output logic             zero
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic [IDXW-1:0]  idx_r;
    logic             cy_out_r;
    logic             ovf_r;
    logic             zero_r;
    logic             last_s;

    // The slice in progress is the most significant one.
    assign last_s = (idx_r == IDXW'(NBYTES - 1));

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE lasts one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand capture, per-byte result assembly and final flag update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            idx_r    <= {IDXW{1'b0}};
            cy_out_r <= 1'b0;
            ovf_r    <= 1'b0;
            zero_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= op_a;
                        b_r     <= sub ? ~op_b : op_b;
                        carry_r <= sub ? 1'b1 : cin;
                        idx_r   <= {IDXW{1'b0}};
                    end
                end
                RUN: begin
                    result_r[8*idx_r +: 8] <= add_sum;
                    carry_r                <= add_cy_out;
                    idx_r                  <= idx_r + IDXW'(1);
                    if (last_s) begin
                        cy_out_r <= add_cy_out;
                        // Operands of equal sign producing a result of the other sign.
                        ovf_r    <= (a_r[WIDTH-1] ~^ b_r[WIDTH-1]) &
                                    (a_r[WIDTH-1] ^ add_sum[7]);
                        // Lower bytes are already in result_r; MSB byte arrives now.
                        zero_r   <= (result_r[WIDTH-9:0] == {(WIDTH-8){1'b0}}) &
                                    (add_sum == 8'h00);
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Adder operand steering: the current byte slice in RUN, zero elsewhere.
    always_comb begin
        add_a     = 8'h00;
        add_b     = 8'h00;
        add_cy_in = 1'b0;
        if (state_r == RUN) begin
            add_a     = a_r[8*idx_r +: 8];
            add_b     = b_r[8*idx_r +: 8];
            add_cy_in = carry_r;
        end else begin
            add_a     = 8'h00;
            add_b     = 8'h00;
            add_cy_in = 1'b0;
        end
    end

    assign busy   = (state_r == RUN);
    assign done   = (state_r == DONE);
    assign result = result_r;
    assign cy_out = cy_out_r;
    assign ovf    = ovf_r;
    assign zero   = zero_r;

endmodule

// File: tb/tb_byte_serial_adder_seq.sv
// Testbench for byte_serial_adder_seq (WIDTH=32) with a behavioural 8-bit
// adder attached. Expected responses are queued at issue time and checked
// by a monitor whenever done is observed.
module tb_byte_serial_adder_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic        cin;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cy_in;
    logic [7:0]  add_sum;
    logic        add_cy_out;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        cy_out;
    logic        ovf;
    logic        zero;

    logic [8:0]  add_full;

    typedef struct packed {
        logic [31:0] res;
        logic        cy;
        logic        ov;
        logic        z;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   errors;

    byte_serial_adder_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sub        (sub),
        .cin        (cin),
        .op_a       (op_a),
        .op_b       (op_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cy_in  (add_cy_in),
        .add_sum    (add_sum),
        .add_cy_out (add_cy_out),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .cy_out     (cy_out),
        .ovf        (ovf),
        .zero       (zero)
    );

    // The 8-bit ripple-carry adder the sequencer drives.
    assign add_full   = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cy_in};
    assign add_sum    = add_full[7:0];
    assign add_cy_out = add_full[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Issue one operation from IDLE; operands are scrambled right after start.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic c,
                         input logic [31:0] er, input logic ecy, input logic eov, input logic ez);
        exp_t e;
        e.res = er; e.cy = ecy; e.ov = eov; e.z = ez;
        sb_q.push_back(e);
        op_a  = a;
        op_b  = b;
        sub   = s;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = ~a;
        op_b  = ~b;
        sub   = ~s;
        cin   = ~c;
    endtask

    // Wait for done (bounded); report cycle of done, busy cycles and cycle-1 adder bus.
    task automatic wait_done(output int n_done, output int n_busy,
                             output logic [7:0] c1a, output logic [7:0] c1b, output logic c1cy);
        n_done = 0;
        n_busy = 0;
        c1a = 8'h00; c1b = 8'h00; c1cy = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin
                c1a = add_a; c1b = add_b; c1cy = add_cy_in;
            end
            if (busy) n_busy++;
            if (done) begin
                n_done = n;
                break;
            end
        end
        if (n_done == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=none expected=done within 20 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=done expected=no done");
                end else begin
                    e = sb_q.pop_front();
                    chk("result", result, e.res);
                    chk("cy_out", {31'd0, cy_out}, {31'd0, e.cy});
                    chk("ovf",    {31'd0, ovf},    {31'd0, e.ov});
                    chk("zero",   {31'd0, zero},   {31'd0, e.z});
                end
            end
        end
    end

    initial begin
        int          nd;
        int          nb;
        logic [7:0]  c1a;
        logic [7:0]  c1b;
        logic        c1cy;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        sub    = 1'b0;
        cin    = 1'b0;
        op_a   = 32'h0000_0000;
        op_b   = 32'h0000_0000;

        // Reset state
        #3;
        chk("rst_busy",   {31'd0, busy},   32'd0);
        chk("rst_done",   {31'd0, done},   32'd0);
        chk("rst_result", result,          32'd0);
        chk("rst_flags",  {29'd0, cy_out, ovf, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Add with byte-0 carry, latency and cycle-1 adder bus
        issue(32'h0000_0081, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0083, 1'b0, 1'b0, 1'b0);
        wait_done(nd, nb, c1a, c1b, c1cy);
        chk("add_c1_a",  {24'd0, c1a}, 32'h81);
        chk("add_c1_b",  {24'd0, c1b}, 32'h01);
        chk("add_c1_cy", {31'd0, c1cy}, 32'd1);
        chk("add_done_cycle", nd, 32'd5);
        chk("add_busy_cycles", nb, 32'd4);
        repeat (3) @(posedge clk);
        #1;
        chk("result_hold", result, 32'h0000_0083);

        // Full ripple
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        wait_done(nd, nb, c1a, c1b, c1cy);

        // Subtract with borrow
        issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        wait_done(nd, nb, c1a, c1b, c1cy);
        chk("sub_c1_a",  {24'd0, c1a}, 32'h05);
        chk("sub_c1_b",  {24'd0, c1b}, 32'hF8);
        chk("sub_c1_cy", {31'd0, c1cy}, 32'd1);

        // Signed overflow, add then subtract
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        wait_done(nd, nb, c1a, c1b, c1cy);
        issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        wait_done(nd, nb, c1a, c1b, c1cy);

        // Start during RUN is ignored
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
        fork
            wait_done(nd, nb, c1a, c1b, c1cy);
            begin
                @(posedge clk);
                #1;
                start = 1'b1;
                op_a  = 32'hFFFF_FFFF;
                op_b  = 32'h0000_0003;
                sub   = 1'b1;
                @(posedge clk);
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        chk("ign_busy_cycles", nb, 32'd4);
        chk("ign_done_cycle", nd, 32'd5);
        repeat (6) @(posedge clk);
        #1;
        chk("ign_idle_busy", {31'd0, busy}, 32'd0);

        // Mid-operation reset
        issue(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        void'(sb_q.pop_back());
        #1;
        chk("mrst_busy",   {31'd0, busy},   32'd0);
        chk("mrst_done",   {31'd0, done},   32'd0);
        chk("mrst_result", result,          32'd0);
        chk("mrst_flags",  {29'd0, cy_out, ovf, zero}, 32'd0);
        chk("mrst_bus",    {15'd0, add_a, add_b, add_cy_in}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("mrst_idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // Fresh operation after reset
        issue(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        wait_done(nd, nb, c1a, c1b, c1cy);
        chk("fresh_done_cycle", nd, 32'd5);

        repeat (2) @(posedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
